// File: rtl/multi_range_pkg.sv
// Shared types and the signed range-membership helper for the multi_range generator.
package multi_range_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest operand the helper accepts; callers sign-extend their WIDTH-bit values to it.
  localparam int MAX_W = 64;

  // A value is inside the range while it has not yet reached the limit in the step direction.
  function automatic logic in_range_f(input logic signed [MAX_W-1:0] cur,
                                      input logic signed [MAX_W-1:0] step,
                                      input logic signed [MAX_W-1:0] limit);
    logic res;
    if (step > 0) res = (cur < limit);
    else          res = (cur > limit);
    return res;
  endfunction

endpackage

// File: rtl/range_step_unit.sv
// Combinational arithmetic for one generator step: range test, next value and signed overflow.
module range_step_unit
  import multi_range_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] cur_i,
  input  logic signed [WIDTH-1:0] step_i,
  input  logic signed [WIDTH-1:0] limit_i,
  output logic                    in_range_o,
  output logic signed [WIDTH-1:0] next_o,
  output logic                    ovf_o
);

  logic [WIDTH:0] sum;

  // One guard bit: the sum overflowed iff the guard and the sign bit disagree.
  assign sum        = {cur_i[WIDTH-1], cur_i} + {step_i[WIDTH-1], step_i};
  assign next_o     = sum[WIDTH-1:0];
  assign ovf_o      = sum[WIDTH] ^ sum[WIDTH-1];
  assign in_range_o = in_range_f(MAX_W'(cur_i), MAX_W'(step_i), MAX_W'(limit_i));

endmodule

// File: rtl/multi_range.sv
// Repeating range(base, limit, step) generator with a start/ready/valid/done handshake.
// Build option: define MULTI_RANGE_SATURATE_EN to end a pass on signed overflow instead of wrapping.
module multi_range
  import multi_range_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic                    _ready,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic        [CNT_W-1:0] repeats,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0,
  output logic        [CNT_W-1:0] _1
);

  // Handshake: an item is transferred on a rising edge where _valid && _ready;
  // while _valid && !_ready the item and _valid are held unchanged.

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] base_q, limit_q, step_q;
  logic        [CNT_W-1:0] rep_q;
  logic signed [WIDTH-1:0] cur_q, cur_d;
  logic        [CNT_W-1:0] pass_q, pass_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic signed [WIDTH-1:0] val_q, val_d;
  logic        [CNT_W-1:0] idx_q, idx_d;
  logic                    first_q, first_d;
  logic                    stop_q, stop_d;
  logic                    load;

  logic                    in_range;
  logic signed [WIDTH-1:0] next;
  logic                    ovf;

  range_step_unit #(.WIDTH(WIDTH)) u_step (
    .cur_i      (cur_q),
    .step_i     (step_q),
    .limit_i    (limit_q),
    .in_range_o (in_range),
    .next_o     (next),
    .ovf_o      (ovf)
  );

`ifndef MULTI_RANGE_SATURATE_EN
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pass_d  = pass_q;
    valid_d = valid_q;
    done_d  = done_q;
    val_d   = val_q;
    idx_d   = idx_q;
    first_d = first_q;
    stop_d  = stop_q;
    load    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (_start) begin
          load    = 1'b1;
          cur_d   = base;
          pass_d  = '0;
          done_d  = 1'b0;
          valid_d = 1'b0;
          first_d = 1'b1;
          stop_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!valid_q || _ready) begin
          // Every pass is identical, so an empty first pass means no items at all.
          if (step_q == '0 || rep_q == '0 || (first_q && pass_q == '0 && !in_range)) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (in_range && !stop_q) begin
            val_d   = cur_q;
            idx_d   = pass_q;
            valid_d = 1'b1;
            cur_d   = next;
            first_d = 1'b0;
`ifdef MULTI_RANGE_SATURATE_EN
            stop_d  = ovf;
`endif
          end else begin
            valid_d = 1'b0;
            pass_d  = pass_q + CNT_W'(1);
            cur_d   = base_q;
            first_d = 1'b1;
            stop_d  = 1'b0;
            if (pass_q + CNT_W'(1) == rep_q) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (!_reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
      rep_q   <= '0;
      cur_q   <= '0;
      pass_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      val_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        base_q  <= base;
        limit_q <= limit;
        step_q  <= step;
        rep_q   <= repeats;
      end
      cur_q   <= cur_d;
      pass_q  <= pass_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      stop_q  <= stop_d;
    end
  end

  assign _valid = valid_q;
  assign _done  = done_q;
  assign _0     = val_q;
  assign _1     = idx_q;

endmodule

// File: tb/tb_multi_range.sv
// Self-checking bench for multi_range: directed cases plus randomized ranges against a list model.
module tb_multi_range;

  localparam int W  = 32;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic                 ready = 1'b1;
  logic signed [W-1:0]  base_i = '0, limit_i = '0, step_i = '0;
  logic        [CW-1:0] rep_i = '0;
  logic                 valid, done;
  logic signed [W-1:0]  v0;
  logic        [CW-1:0] v1;

  logic                 start8 = 1'b0;
  logic                 ready8 = 1'b1;
  logic signed [7:0]    base8 = '0, limit8 = '0, step8 = '0;
  logic        [CW-1:0] rep8 = '0;
  logic                 valid8, done8;
  logic signed [7:0]    v08;
  logic        [CW-1:0] v18;

  multi_range #(.WIDTH(W), .CNT_W(CW)) dut (
    ._clock(clk), ._reset(rst_n), ._start(start), ._ready(ready),
    .base(base_i), .limit(limit_i), .step(step_i), .repeats(rep_i),
    ._valid(valid), ._done(done), ._0(v0), ._1(v1)
  );

  multi_range #(.WIDTH(8), .CNT_W(CW)) dut8 (
    ._clock(clk), ._reset(rst_n), ._start(start8), ._ready(ready8),
    .base(base8), .limit(limit8), .step(step8), .repeats(rep8),
    ._valid(valid8), ._done(done8), ._0(v08), ._1(v18)
  );

  // ---------------- scoreboard ----------------
  logic [W+CW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected item list straight from the range definition, pass by pass.
  function automatic int build_model(input longint b, input longint l, input longint s,
                                     input int rep, input int w, input int cap);
    longint mx, mn, v, nv;
    int n, per;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    exp_q.delete();
    n = 0;
    per = 0;
    if (s == 0) return 0;
    for (int p = 0; p < rep; p++) begin
      v = b;
      per = 0;
      while ((s > 0) ? (v < l) : (v > l)) begin
        if (n >= cap) return per;
        exp_q.push_back({CW'(p), W'(v)});
        n++;
        per++;
        nv = v + s;
        if (nv > mx || nv < mn) begin
`ifdef MULTI_RANGE_SATURATE_EN
          break;
`else
          nv = (nv > mx) ? nv - (longint'(1) <<< w) : nv + (longint'(1) <<< w);
`endif
        end
        v = nv;
      end
    end
    return per;
  endfunction

  // ---------------- driver ----------------
  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_case(input longint b, input longint l, input longint s,
                          input int rep, input int mode, input string tag);
    int per, exp_edges, edges, done_edge, rcnt;
    logic stalled;
    logic [W+CW-1:0] held, exp_item;
    per = build_model(b, l, s, rep, W, 100000);
    exp_edges = (per == 0 || rep == 0) ? 2 : 1 + rep * (per + 1);
    @(negedge clk);
    base_i = W'(b); limit_i = W'(l); step_i = W'(s); rep_i = CW'(rep);
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1; done_edge = -1; rcnt = 0; stalled = 1'b0; held = '0;
    while (edges < 5000) begin
      if (stalled) check({tag, "_hold"}, 64'({valid, v1, v0}), 64'({1'b1, held}));
      if (done === 1'b1) begin
        done_edge = edges;
        break;
      end
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      rcnt++;
      if (valid === 1'b1 && ready) begin
        exp_item = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_item"}, 64'({v1, v0}), 64'(exp_item));
      end
      stalled = (valid === 1'b1) && !ready;
      held = {v1, v0};
      @(negedge clk);
      edges++;
    end
    ready = 1'b1;
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_valid_at_done"}, 64'(valid), 64'(0));
    check({tag, "_items_left"}, 64'(exp_q.size()), 64'(0));
    if (mode == 0) check({tag, "_done_edge"}, 64'(done_edge), 64'(exp_edges));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int per8, edges;
    logic any_x;
    logic [W+CW-1:0] exp_item;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({valid, done, v1, v0}), 64'(0));
    check("reset_outs8", 64'({valid8, done8, v18, v08}), 64'(0));
    rst_n = 1'b1;

    run_case(0, 10, 2, 2, 0, "t1");
    run_case(5, -1, -2, 1, 0, "t2");
    run_case(0, 10, 2, 2, 1, "t3");
    run_case(0, 10, 0, 3, 0, "t4_step0");
    run_case(0, 10, 1, 0, 0, "t4_rep0");
    run_case(10, 0, 1, 2, 0, "t4_empty");

    // Reset three cycles into a T1 run; _start asserted during reset must be ignored.
    @(negedge clk);
    base_i = 0; limit_i = 10; step_i = 2; rep_i = 2; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("t5_reset_outs", 64'({valid, done, v1, v0}), 64'(0));
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_idle_after", 64'({valid, done}), 64'(0));
    run_case(0, 10, 2, 2, 0, "t5_rerun");

    for (int i = 0; i < 20; i++) begin
      longint b, l, s;
      int rep;
      b   = longint'($urandom_range(0, 80)) - 40;
      l   = longint'($urandom_range(0, 80)) - 40;
      s   = longint'($urandom_range(0, 14)) - 7;
      rep = int'($urandom_range(0, 3));
      run_case(b, l, s, rep, (i % 2 == 0) ? 0 : 2, $sformatf("rnd%0d", i));
    end

    // 8-bit instance near the positive extreme.
`ifdef MULTI_RANGE_SATURATE_EN
    per8 = build_model(120, 127, 5, 1, 8, 100);
`else
    per8 = build_model(120, 127, 5, 1, 8, 3);
`endif
    @(negedge clk);
    base8 = 8'sd120; limit8 = 8'sd127; step8 = 8'sd5; rep8 = 1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    edges = 1;
    any_x = 1'b0;
    while (edges < 40) begin
      if ($isunknown({valid8, done8, v18, v08})) any_x = 1'b1;
`ifdef MULTI_RANGE_SATURATE_EN
      if (done8 === 1'b1) break;
`else
      if (exp_q.size() == 0) break;
`endif
      if (valid8 === 1'b1) begin
        exp_item = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("t6_item", 64'({v18, W'(v08)}), 64'(exp_item));
      end
      @(negedge clk);
      edges++;
    end
    check("t6_no_x", 64'(any_x), 64'(0));
    check("t6_items_left", 64'(exp_q.size()), 64'(0));
`ifdef MULTI_RANGE_SATURATE_EN
    check("t6_done", 64'({done8, valid8}), 64'(2'b10));
    check("t6_per_pass", 64'(per8), 64'(2));
`else
    check("t6_per_pass", 64'(per8), 64'(3));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
